fir_filter_tdm: RTL

FIR_FILTER_TDM -- requirements
Module: fir_filter_tdm

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_mac.sv | 30 +++
 rtl/fir_filter_tdm.sv | 115 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants, coefficient word type and output saturation for the TDM FIR.
package fir_pkg;

  localparam int SAT_W = 64;

  typedef logic signed [31:0] coef_word_t;

  function automatic int acc_width(input int wx, input int wb, input int n);
    return wx + wb + $clog2(n);
  endfunction

  // Clamp or wrap v to a wy-bit signed range; the caller keeps the low wy bits.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int wy, input bit sat);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (wy - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wy - 1));
    if (!sat) return (v <<< (SAT_W - wy)) >>> (SAT_W - wy);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Combinational N-tap dot product with output saturation, shared by all channels.
module fir_mac
  import fir_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH_X = 8,
  parameter int WIDTH_B = 8,
  parameter int WIDTH_Y = 18,
  parameter int SAT     = 1
) (
  input  logic [N*WIDTH_X-1:0] i_x,
  input  logic [N*WIDTH_B-1:0] i_b,
  output logic [WIDTH_Y-1:0]   o_y
);

  localparam int AW = acc_width(WIDTH_X, WIDTH_B, N);

  logic signed [AW-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < N; k++) begin
      w_acc = w_acc + AW'($signed(i_x[k*WIDTH_X +: WIDTH_X])) *
                      AW'($signed(i_b[k*WIDTH_B +: WIDTH_B]));
    end
  end

  assign o_y = WIDTH_Y'(saturate(SAT_W'(w_acc), WIDTH_Y, SAT != 0));

endmodule

// File: rtl/fir_filter_tdm.sv
// Multi-channel FIR sharing one MAC; per-channel delay lines, double-buffered
// coefficients and a one-deep output register with valid/ready handshakes.
module fir_filter_tdm
  import fir_pkg::*;
#(
  parameter int         N       = 4,
  parameter int         C       = 2,
  parameter int         WIDTH_X = 8,
  parameter int         WIDTH_B = 8,
  parameter int         WIDTH_Y = 18,
  parameter int         SAT     = 1,
  parameter coef_word_t B_INIT [N] = '{32'sd1, 32'sd2, 32'sd3, 32'sd4},
  localparam int        CW      = (C > 1) ? $clog2(C) : 1,
  localparam int        AWC     = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH_X-1:0] s_data,
  input  logic [CW-1:0]      s_ch,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH_Y-1:0] m_data,
  output logic [CW-1:0]      m_ch,
  input  logic               coef_we,
  input  logic [AWC-1:0]     coef_addr,
  input  logic [WIDTH_B-1:0] coef_data,
  input  logic               coef_commit,
  output logic               ch_err
);

  // The incoming sample is tap 0, so only N-1 past samples need storing.
  localparam int DL = (N > 1) ? N - 1 : 1;

  logic [WIDTH_X-1:0]   r_dl [C][DL];
  logic [WIDTH_B-1:0]   r_shadow [N];
  logic [WIDTH_B-1:0]   r_active [N];
  logic [WIDTH_B-1:0]   w_shadow_nx [N];
  logic                 r_m_valid;
  logic                 r_ch_err;
  logic [WIDTH_Y-1:0]   r_m_data;
  logic [CW-1:0]        r_m_ch;
  logic                 w_accept;
  logic                 w_ch_ok;
  logic [CW-1:0]        w_ch_idx;
  logic [N*WIDTH_X-1:0] w_x;
  logic [N*WIDTH_B-1:0] w_b;
  logic [WIDTH_Y-1:0]   w_y;

  assign s_ready  = !r_m_valid || m_ready;
  assign w_accept = s_valid && s_ready;
  assign w_ch_ok  = int'(s_ch) < C;
  assign w_ch_idx = w_ch_ok ? s_ch : '0;

  always_comb begin
    w_x = '0;
    w_b = '0;
    w_x[WIDTH_X-1:0] = s_data;
    for (int k = 1; k < N; k++) w_x[k*WIDTH_X +: WIDTH_X] = r_dl[w_ch_idx][k-1];
    for (int k = 0; k < N; k++) w_b[k*WIDTH_B +: WIDTH_B] = r_active[k];
  end

  // A write on the commit edge must land in the committed bank.
  always_comb begin
    w_shadow_nx = r_shadow;
    if (coef_we && int'(coef_addr) < N) w_shadow_nx[coef_addr] = coef_data;
  end

  fir_mac #(
    .N(N), .WIDTH_X(WIDTH_X), .WIDTH_B(WIDTH_B), .WIDTH_Y(WIDTH_Y), .SAT(SAT)
  ) u_mac (
    .i_x(w_x),
    .i_b(w_b),
    .o_y(w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_ch    <= '0;
      r_ch_err  <= 1'b0;
      for (int c = 0; c < C; c++)
        for (int j = 0; j < DL; j++) r_dl[c][j] <= '0;
      for (int k = 0; k < N; k++) begin
        r_shadow[k] <= WIDTH_B'(B_INIT[k]);
        r_active[k] <= WIDTH_B'(B_INIT[k]);
      end
    end else begin
      r_ch_err <= w_accept && !w_ch_ok;
      r_shadow <= w_shadow_nx;
      if (coef_commit) r_active <= w_shadow_nx;
      for (int c = 0; c < C; c++) begin
        if (w_accept && w_ch_ok && int'(s_ch) == c) begin
          r_dl[c][0] <= s_data;
          for (int j = 1; j < DL; j++) r_dl[c][j] <= r_dl[c][j-1];
        end
      end
      if (w_accept && w_ch_ok) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_y;
        r_m_ch    <= s_ch;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_ch    = r_m_ch;
  assign ch_err  = r_ch_err;

endmodule
